kamus_mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer for the kamus-v core. It shares one word-wide memory port between the instruction-fetch stage (IF) and the load/store unit (LSU), and converts LSU `mem_width_e` accesses (B/H/W) into word-aligned requests with byte enables. It also detects misaligned accesses and applies a starvation guard so that sustained LSU traffic cannot block fetch. It sits between the core pipeline and the L1 memory / bus interface.

---
 rtl/kamus_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_kamus_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/kamus_mem_arbiter.sv
// kamus_mem_arbiter: shares one word-wide memory port between instruction
// fetch and the LSU. LSU has priority, with a starvation guard for fetch.
// LSU B/H/W accesses become word-aligned requests with byte enables, and
// misaligned accesses get an error response without touching memory.
module kamus_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // instruction fetch
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    // load/store unit
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [1:0]  lsu_width_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    // memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_e;

    // Counter holds 0..STARVE_LIMIT; the +2 keeps the width >= 1 for a limit of 0.
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt;
    logic          owner_lsu;          // 1: LSU owns the transaction, 0: fetch
    logic [31:0]   addr_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic          if_starved, lsu_win, if_win;
    logic [31:0]   sel_addr, sel_wdata;
    logic          sel_we, sel_misal;
    logic [3:0]    sel_be;
    logic          in_req, gnt, rsp;

    // Arbitration: LSU first unless fetch has waited out its budget.
    always_comb begin
        if_starved = if_req_i && (starve_cnt == LIMIT);
        lsu_win    = lsu_req_i && !if_starved;
        if_win     = if_req_i && !lsu_win;
    end

    // Payload of the winner: byte lanes, replicated write data, alignment check.
    always_comb begin
        sel_addr  = if_addr_i;
        sel_we    = 1'b0;
        sel_be    = 4'b1111;
        sel_wdata = '0;
        sel_misal = |if_addr_i[1:0];
        if (lsu_win) begin
            sel_addr  = lsu_addr_i;
            sel_we    = lsu_we_i;
            sel_wdata = lsu_wdata_i;
            sel_misal = 1'b0;
            case (lsu_width_i)
                2'b00: begin
                    sel_be    = 4'b0001 << lsu_addr_i[1:0];
                    sel_wdata = {4{lsu_wdata_i[7:0]}};
                end
                2'b01: begin
                    sel_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                    sel_wdata = {2{lsu_wdata_i[15:0]}};
                    sel_misal = lsu_addr_i[0];
                end
                2'b10:   sel_misal = |lsu_addr_i[1:0];
                default: sel_misal = 1'b1;
            endcase
        end
    end

    // Next state. An error transaction goes ERR (grant) -> RSP (error response).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lsu_win || if_win) state_d = sel_misal ? ERR : REQ;
            REQ:     if (mem_gnt_i) state_d = RSP;
            RSP:     if (err_q || mem_rvalid_i) state_d = IDLE;
            ERR:     state_d = RSP;
            default: state_d = IDLE;
        endcase
    end

    // State, latched transaction and starvation counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            starve_cnt <= '0;
            owner_lsu  <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (lsu_win || if_win) begin
                    owner_lsu <= lsu_win;
                    addr_q    <= sel_addr;
                    we_q      <= sel_we;
                    be_q      <= sel_be;
                    wdata_q   <= sel_wdata;
                    err_q     <= sel_misal;
                end
                if (lsu_win && if_req_i)
                    starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
                else if (if_win || !if_req_i)
                    starve_cnt <= '0;
            end
        end
    end

    // Outputs: memory side only driven in REQ, responses only toward the owner.
    always_comb begin
        in_req = (state_q == REQ);
        gnt    = (in_req && mem_gnt_i) || (state_q == ERR);
        rsp    = (state_q == RSP) && (err_q || mem_rvalid_i);

        mem_req_o   = in_req;
        mem_we_o    = in_req && we_q;
        mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
        mem_be_o    = in_req ? be_q : '0;
        mem_wdata_o = in_req ? wdata_q : '0;

        lsu_gnt_o    = gnt && owner_lsu;
        if_gnt_o     = gnt && !owner_lsu;
        lsu_rvalid_o = rsp && owner_lsu;
        if_rvalid_o  = rsp && !owner_lsu;
        lsu_err_o    = lsu_rvalid_o && err_q;
        if_err_o     = if_rvalid_o && err_q;

        // Load data is right-aligned; writes and errors return zero.
        lsu_rdata_o = (lsu_rvalid_o && !we_q && !err_q) ?
                      (mem_rdata_i >> {addr_q[1:0], 3'b000}) : '0;
        if_rdata_o  = (if_rvalid_o && !err_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_kamus_mem_arbiter.sv
// Directed bench for kamus_mem_arbiter: inputs change 1ns after the rising
// edge, outputs are checked 1ns later, mid-cycle.
module tb_kamus_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic [1:0]  lsu_width_i;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_chk = 0;
    int n_err = 0;

    kamus_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
        .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_width_i(lsu_width_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // all observable outputs OR-reduced to one flag
    function automatic logic any_out();
        return if_gnt_o | if_rvalid_o | if_err_o | (|if_rdata_o) |
               lsu_gnt_o | lsu_rvalid_o | lsu_err_o | (|lsu_rdata_o) |
               mem_req_o | mem_we_o | (|mem_addr_o) | (|mem_be_o) | (|mem_wdata_o);
    endfunction

    // Issue one LSU misaligned access from an IDLE cycle; expect the ERR sequence.
    task automatic lsu_err_case(input string tag, input logic [31:0] a, input logic [1:0] w);
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = a; lsu_width_i = w;
        tick();                                   // N+1: ERR
        #1;
        chk({tag, "_gnt"}, lsu_gnt_o, 1);
        chk({tag, "_memreq1"}, mem_req_o, 0);
        lsu_req_i = 0;
        tick();                                   // N+2: error response
        #1;
        chk({tag, "_rvalid"}, lsu_rvalid_o, 1);
        chk({tag, "_err"}, lsu_err_o, 1);
        chk({tag, "_memreq2"}, mem_req_o, 0);
        tick();                                   // N+3: IDLE
        #1;
        chk({tag, "_idle"}, {31'b0, any_out()}, 0);
    endtask

    initial begin
        rst_ni = 0; if_req_i = 0; if_addr_i = 0;
        lsu_req_i = 0; lsu_we_i = 0; lsu_addr_i = 0; lsu_width_i = 0; lsu_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;

        // reset state
        tick(); tick();
        #1;
        chk("rst_outputs", {31'b0, any_out()}, 0);
        chk("rst_memreq", mem_req_o, 0);
        rst_ni = 1;
        tick();

        // LB at 0x1003
        lsu_req_i = 1; lsu_addr_i = 32'h1003; lsu_width_i = 2'b00;
        #1;
        chk("lb_idle_gnt", lsu_gnt_o, 0);
        tick();
        mem_gnt_i = 1;
        #1;
        chk("lb_memreq", mem_req_o, 1);
        chk("lb_addr", mem_addr_o, 32'h1000);
        chk("lb_be", mem_be_o, 4'b1000);
        chk("lb_we", mem_we_o, 0);
        chk("lb_gnt", {if_gnt_o, lsu_gnt_o}, 2'b01);
        tick();
        lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAABBCCDD;
        #1;
        chk("lb_rvalid", lsu_rvalid_o, 1);
        chk("lb_rdata", lsu_rdata_o, 32'h000000AA);
        chk("lb_err", lsu_err_o, 0);
        tick();
        mem_rvalid_i = 0;
        #1;
        chk("lb_done", {31'b0, any_out()}, 0);

        // SH at 0x2002
        lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 32'h2002; lsu_width_i = 2'b01;
        lsu_wdata_i = 32'h0000BEEF;
        tick();
        mem_gnt_i = 1;
        #1;
        chk("sh_be", mem_be_o, 4'b1100);
        chk("sh_wdata", mem_wdata_o, 32'hBEEFBEEF);
        chk("sh_we", mem_we_o, 1);
        chk("sh_addr", mem_addr_o, 32'h2000);
        tick();
        lsu_req_i = 0; lsu_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
        #1;
        chk("sh_rvalid", lsu_rvalid_o, 1);
        chk("sh_rdata", lsu_rdata_o, 0);
        tick();
        mem_rvalid_i = 0;

        // misaligned LW and illegal width
        lsu_err_case("lw_mis", 32'h0006, 2'b10);
        lsu_err_case("width11", 32'h0000, 2'b11);

        // starvation guard: both requesting continuously
        if_req_i = 1; if_addr_i = 32'h100;
        lsu_req_i = 1; lsu_addr_i = 32'h200; lsu_width_i = 2'b10;
        for (int i = 0; i < 10; i++) begin
            logic exp_if;
            exp_if = (i == 4) || (i == 9);
            tick();
            mem_gnt_i = 1;
            #1;
            chk($sformatf("starve_gnt%0d", i), {if_gnt_o, lsu_gnt_o}, {exp_if, !exp_if});
            chk($sformatf("starve_addr%0d", i), mem_addr_o, exp_if ? 32'h100 : 32'h200);
            tick();
            mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hC0DE0000 + i;
            #1;
            chk($sformatf("starve_rv%0d", i), {if_rvalid_o, lsu_rvalid_o}, {exp_if, !exp_if});
            if (exp_if) chk($sformatf("starve_ifdata%0d", i), if_rdata_o, 32'hC0DE0000 + i);
            tick();
            mem_rvalid_i = 0;
        end
        if_req_i = 0; lsu_req_i = 0;

        // grant stall with spurious rvalid during REQ
        tick();
        if_req_i = 1; if_addr_i = 32'h3000;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_rvalid_i = (i == 2);
            mem_rdata_i = 32'hDEADDEAD;
            #1;
            chk($sformatf("stall_req%0d", i), mem_req_o, 1);
            chk($sformatf("stall_addr%0d", i), mem_addr_o, 32'h3000);
            chk($sformatf("stall_be%0d", i), mem_be_o, 4'b1111);
            chk($sformatf("stall_gnt%0d", i), if_gnt_o, 0);
            chk($sformatf("stall_rv%0d", i), if_rvalid_o, 0);
            tick();
        end
        mem_rvalid_i = 0; mem_gnt_i = 1;
        #1;
        chk("stall_gnt", if_gnt_o, 1);
        chk("stall_lsugnt", lsu_gnt_o, 0);
        tick();
        if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        #1;
        chk("stall_rvalid", if_rvalid_o, 1);
        chk("stall_rdata", if_rdata_o, 32'hCAFEF00D);
        chk("stall_lsurv", lsu_rvalid_o, 0);
        tick();
        mem_rvalid_i = 0;

        // reset during RSP
        lsu_req_i = 1; lsu_addr_i = 32'h40; lsu_width_i = 2'b10;
        tick();
        mem_gnt_i = 1;
        #1;
        chk("rrsp_gnt", lsu_gnt_o, 1);
        tick();
        lsu_req_i = 0; mem_gnt_i = 0; rst_ni = 0;
        tick();
        rst_ni = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h99999999;
        #1;
        chk("rrsp_idle", {31'b0, any_out()}, 0);
        chk("rrsp_late_rv", lsu_rvalid_o, 0);
        tick();
        mem_rvalid_i = 0;
        lsu_req_i = 1; lsu_addr_i = 32'h44; lsu_width_i = 2'b10;
        tick();
        mem_gnt_i = 1;
        #1;
        chk("rrsp_new_addr", mem_addr_o, 32'h44);
        chk("rrsp_new_gnt", lsu_gnt_o, 1);
        tick();
        lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55667788;
        #1;
        chk("rrsp_new_rv", lsu_rvalid_o, 1);
        chk("rrsp_new_data", lsu_rdata_o, 32'h55667788);
        tick();
        mem_rvalid_i = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
